// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, memory-stage and memory-port signals of the shared port arbiter
interface mem_port_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   logic              if_stall;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_done;
   logic              mem_stall;
   logic              port_req;
   logic              port_we;
   logic [ADDR_W-1:0] port_addr;
   logic [DATA_W-1:0] port_wdata;
   logic              port_ack;
   logic [DATA_W-1:0] port_rdata;
   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, port_ack, port_rdata,
      output if_rdata, if_valid, if_stall, mem_rdata, mem_done, mem_stall,
             port_req, port_we, port_addr, port_wdata
   );
   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, port_ack, port_rdata,
      input  if_rdata, if_valid, if_stall, mem_rdata, mem_done, mem_stall,
             port_req, port_we, port_addr, port_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and memory stage; memory stage wins
// except when fetch has lost STARVE_MAX consecutive contended decisions.
module mem_port_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);
   localparam int CW = $clog2(STARVE_MAX + 1);
   typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MEM, RESP} state_t;
   state_t            state_q;
   logic [CW-1:0]     starve_q;
   logic              abandon_q;
   logic              port_req_q;
   logic              port_we_q;
   logic [ADDR_W-1:0] port_addr_q;
   logic [DATA_W-1:0] port_wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] mem_rdata_q;
   logic              if_valid_q;
   logic              mem_done_q;
   logic              gnt_if_d;
   logic              gnt_mem_d;
   logic              starve_hit;
   always_comb begin
      starve_hit = starve_q == CW'(STARVE_MAX);
      gnt_if_d   = bus.if_req && (!bus.mem_req || starve_hit);
      gnt_mem_d  = bus.mem_req && !gnt_if_d;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         starve_q     <= '0;
         abandon_q    <= 1'b0;
         port_req_q   <= 1'b0;
         port_we_q    <= 1'b0;
         port_addr_q  <= '0;
         port_wdata_q <= '0;
         if_rdata_q   <= '0;
         mem_rdata_q  <= '0;
         if_valid_q   <= 1'b0;
         mem_done_q   <= 1'b0;
      end else begin
         if_valid_q <= 1'b0;
         mem_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               abandon_q <= 1'b0;
               if (gnt_if_d) begin
                  state_q      <= GNT_IF;
                  starve_q     <= '0;
                  port_req_q   <= 1'b1;
                  port_we_q    <= 1'b0;
                  port_addr_q  <= bus.if_addr;
                  port_wdata_q <= '0;
               end else if (gnt_mem_d) begin
                  state_q      <= GNT_MEM;
                  starve_q     <= !bus.if_req ? '0 : starve_hit ? starve_q : starve_q + CW'(1);
                  port_req_q   <= 1'b1;
                  port_we_q    <= bus.mem_we;
                  port_addr_q  <= bus.mem_addr;
                  port_wdata_q <= bus.mem_wdata;
               end
            end
            GNT_IF: begin
               // a flushed fetch still finishes on the port but never reaches the pipeline
               if (!bus.if_req) abandon_q <= 1'b1;
               if (bus.port_ack) begin
                  state_q    <= RESP;
                  port_req_q <= 1'b0;
                  if (bus.if_req && !abandon_q) begin
                     if_rdata_q <= bus.port_rdata;
                     if_valid_q <= 1'b1;
                  end
               end
            end
            GNT_MEM: begin
               if (bus.port_ack) begin
                  state_q    <= RESP;
                  port_req_q <= 1'b0;
                  mem_done_q <= 1'b1;
                  if (!port_we_q) mem_rdata_q <= bus.port_rdata;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.port_req   = port_req_q;
   assign bus.port_we    = port_we_q;
   assign bus.port_addr  = port_addr_q;
   assign bus.port_wdata = port_wdata_q;
   assign bus.if_rdata   = if_rdata_q;
   assign bus.if_valid   = if_valid_q;
   assign bus.mem_rdata  = mem_rdata_q;
   assign bus.mem_done   = mem_done_q;
   assign bus.if_stall   = bus.if_req && !if_valid_q;
   assign bus.mem_stall  = bus.mem_req && !mem_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: per-cycle vector table plus a contention/starvation sequence
module tb_mem_port_arbiter;
   typedef struct {
      logic        rst, ir;
      logic [31:0] ia;
      logic        mr, mw;
      logic [31:0] ma, mwd;
      logic        ack;
      logic [31:0] prd;
      logic        preq, pwe;
      logic [31:0] pa, pwd;
      logic        iv;
      logic [31:0] ird;
      logic        md;
      logic [31:0] mrd;
      logic        is, ms;
   } vec_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int tests = 0;
   int failed = 0;
   vec_t v[28];
   mem_port_arbiter_if bus ();
   mem_port_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input vec_t t);
      reset          = t.rst;
      bus.if_req     = t.ir;
      bus.if_addr    = t.ia;
      bus.mem_req    = t.mr;
      bus.mem_we     = t.mw;
      bus.mem_addr   = t.ma;
      bus.mem_wdata  = t.mwd;
      bus.port_ack   = t.ack;
      bus.port_rdata = t.prd;
   endtask
   initial begin
      localparam logic [31:0] DB = 32'hDEADBEEF;
      localparam logic [31:0] CF = 32'hCAFEF00D;
      int owner_exp[6];
      int starve_exp[6];
      // rst ir ia | mr mw ma mwd | ack prd || preq pwe pa pwd | iv ird | md mrd | is ms
      v[0]  = '{1, 0, 0,     0, 0, 0, 0,              0, 0,             0, 0, 0, 0,              0, 0,  0, 0,  0, 0};
      v[1]  = '{0, 1, 'h40,  0, 0, 0, 0,              0, 0,             0, 0, 0, 0,              0, 0,  0, 0,  1, 0};
      v[2]  = '{0, 1, 'h40,  0, 0, 0, 0,              1, DB,            1, 0, 'h40, 0,           0, 0,  0, 0,  1, 0};
      v[3]  = '{0, 1, 'h40,  0, 0, 0, 0,              0, 0,             0, 0, 'h40, 0,           1, DB, 0, 0,  0, 0};
      v[4]  = '{0, 0, 'h40,  0, 0, 0, 0,              0, 0,             0, 0, 'h40, 0,           0, DB, 0, 0,  0, 0};
      v[5]  = '{0, 0, 0,     1, 1, 'h100, 'h1234,     0, 0,             0, 0, 'h40, 0,           0, DB, 0, 0,  0, 1};
      v[6]  = '{0, 0, 0,     1, 1, 'h100, 'h1234,     0, 0,             1, 1, 'h100, 'h1234,     0, DB, 0, 0,  0, 1};
      v[7]  = v[6];
      v[8]  = v[6];
      v[9]  = '{0, 0, 0,     1, 1, 'h100, 'h1234,     1, 'h55555555,    1, 1, 'h100, 'h1234,     0, DB, 0, 0,  0, 1};
      v[10] = '{0, 0, 0,     1, 1, 'h100, 'h1234,     0, 0,             0, 1, 'h100, 'h1234,     0, DB, 1, 0,  0, 0};
      v[11] = '{0, 0, 0,     0, 0, 0, 0,              0, 0,             0, 1, 'h100, 'h1234,     0, DB, 0, 0,  0, 0};
      v[12] = '{0, 1, 'h80,  0, 0, 0, 0,              0, 0,             0, 1, 'h100, 'h1234,     0, DB, 0, 0,  1, 0};
      v[13] = '{0, 0, 'h80,  1, 0, 'h200, 0,          0, 0,             1, 0, 'h80, 0,           0, DB, 0, 0,  0, 1};
      v[14] = '{0, 0, 'h80,  1, 0, 'h200, 0,          1, 'hBADBAD00,    1, 0, 'h80, 0,           0, DB, 0, 0,  0, 1};
      v[15] = '{0, 0, 0,     1, 0, 'h200, 0,          0, 0,             0, 0, 'h80, 0,           0, DB, 0, 0,  0, 1};
      v[16] = v[15];
      v[17] = '{0, 0, 0,     1, 0, 'h200, 0,          1, CF,            1, 0, 'h200, 0,          0, DB, 0, 0,  0, 1};
      v[18] = '{0, 0, 0,     1, 0, 'h200, 0,          0, 0,             0, 0, 'h200, 0,          0, DB, 1, CF, 0, 0};
      v[19] = '{0, 0, 0,     0, 0, 0, 0,              0, 0,             0, 0, 'h200, 0,          0, DB, 0, CF, 0, 0};
      v[20] = '{0, 0, 0,     1, 1, 'h300, 'hAAAA,     0, 0,             0, 0, 'h200, 0,          0, DB, 0, CF, 0, 1};
      v[21] = '{0, 0, 0,     1, 1, 'h300, 'hAAAA,     0, 0,             1, 1, 'h300, 'hAAAA,     0, DB, 0, CF, 0, 1};
      v[22] = '{1, 0, 0,     1, 1, 'h300, 'hAAAA,     0, 0,             1, 1, 'h300, 'hAAAA,     0, DB, 0, CF, 0, 1};
      v[23] = '{0, 0, 0,     1, 1, 'h300, 'hAAAA,     0, 0,             0, 0, 0, 0,              0, 0,  0, 0,  0, 1};
      v[24] = '{0, 0, 0,     1, 1, 'h300, 'hAAAA,     0, 0,             1, 1, 'h300, 'hAAAA,     0, 0,  0, 0,  0, 1};
      v[25] = '{0, 0, 0,     1, 1, 'h300, 'hAAAA,     1, 'h12345678,    1, 1, 'h300, 'hAAAA,     0, 0,  0, 0,  0, 1};
      v[26] = '{0, 0, 0,     1, 1, 'h300, 'hAAAA,     0, 0,             0, 1, 'h300, 'hAAAA,     0, 0,  1, 0,  0, 0};
      v[27] = '{0, 0, 0,     0, 0, 0, 0,              0, 0,             0, 1, 'h300, 'hAAAA,     0, 0,  0, 0,  0, 0};
      drive(v[0]);
      step();
      step();
      for (int i = 0; i < 28; i++) begin
         drive(v[i]);
         #1;
         chk($sformatf("r%0d port_req", i),   32'(bus.port_req),  32'(v[i].preq));
         chk($sformatf("r%0d port_we", i),    32'(bus.port_we),   32'(v[i].pwe));
         chk($sformatf("r%0d port_addr", i),  bus.port_addr,      v[i].pa);
         chk($sformatf("r%0d port_wdata", i), bus.port_wdata,     v[i].pwd);
         chk($sformatf("r%0d if_valid", i),   32'(bus.if_valid),  32'(v[i].iv));
         chk($sformatf("r%0d if_rdata", i),   bus.if_rdata,       v[i].ird);
         chk($sformatf("r%0d mem_done", i),   32'(bus.mem_done),  32'(v[i].md));
         chk($sformatf("r%0d mem_rdata", i),  bus.mem_rdata,      v[i].mrd);
         chk($sformatf("r%0d if_stall", i),   32'(bus.if_stall),  32'(v[i].is));
         chk($sformatf("r%0d mem_stall", i),  32'(bus.mem_stall), 32'(v[i].ms));
         if (i == 23) chk("rst_state", 32'(dut.state_q), 32'd0);
         step();
      end
      // both requesters held: four MEM grants, then fetch forced through, then MEM again
      owner_exp  = '{0, 0, 0, 0, 1, 0};
      starve_exp = '{1, 2, 3, 4, 0, 1};
      reset = 1'b1;
      bus.if_req = 1'b1;
      bus.if_addr = 32'h40;
      bus.mem_req = 1'b1;
      bus.mem_we = 1'b0;
      bus.mem_addr = 32'h100;
      bus.mem_wdata = '0;
      bus.port_ack = 1'b1;
      bus.port_rdata = 32'h0BADF00D;
      step();
      chk("starve_rst", 32'(dut.starve_q), 32'd0);
      reset = 1'b0;
      for (int g = 0; g < 6; g++) begin
         int n = 0;
         step();
         while (!bus.port_req && n < 20) begin
            step();
            n++;
         end
         if (n >= 20) begin
            chk($sformatf("g%0d grant_timeout", g), 32'd1, 32'd0);
         end else begin
            chk($sformatf("g%0d owner_is_if", g), 32'(bus.port_addr == 32'h40), 32'(owner_exp[g]));
            chk($sformatf("g%0d starve_cnt", g), 32'(dut.starve_q), 32'(starve_exp[g]));
         end
      end
      bus.if_req = 1'b0;
      bus.mem_req = 1'b0;
      bus.port_ack = 1'b0;
      step();
      step();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing arbiter that shares one single-port unified memory between the instruction-fetch stage and the memory stage of the 5-stage pipeline. It grants the port to one requester at a time and drives the transaction with a req/ack handshake. It returns read data and a one-cycle completion pulse, and generates per-stage stall signals that feed the pipeline freeze logic. The memory stage has priority, and a starvation counter guarantees forward progress for fetch.

## Interface
- DATA_W, 32, data word width (matches processor word length)
- ADDR_W, 32, address width
- STARVE_MAX, 4, consecutive memory-stage wins over a waiting fetch before fetch is forced through (≥1)

- clk  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- if_req  in  1  fetch request; held high with stable if_addr until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, registered, valid when if_valid=1
- if_valid  out  1  one-cycle fetch completion pulse
- if_stall  out  1  combinational: if_req & ~if_valid
- mem_req  in  1  memory-stage request; held with stable mem_we/addr/wdata until mem_done
- mem_we  in  1  1=write, 0=read
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data, registered, valid when mem_done=1
- mem_done  out  1  one-cycle memory-stage completion pulse
- mem_stall  out  1  combinational: mem_req & ~mem_done
- port_req  out  1  memory port request, registered
- port_we  out  1  memory port write enable, registered
- port_addr  out  ADDR_W  registered address
- port_wdata  out  DATA_W  registered write data
- port_ack  in  1  memory accepts/completes access; port_rdata valid in this cycle
- port_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, GNT_IF, GNT_MEM, RESP.
- IDLE: if mem_req & if_req: grant MEM unless starve_cnt == STARVE_MAX, then grant IF. Otherwise grant whichever requester is active. Stay in IDLE if neither is active.
- On grant: latch owner's address/we/wdata into port_*. Fetch always uses port_we=0 and port_wdata=0. Set port_req=1 and go to GNT_IF or GNT_MEM.
- GNT_x: hold port_* stable while port_ack=0, with no timeout. When port_ack=1: capture port_rdata into owner's rdata register (MEM write: mem_rdata unchanged), clear port_req, go to RESP.
- RESP: pulse the owner's if_valid or mem_done for exactly one cycle. Go to IDLE. Requests are not sampled in RESP, which lets the requester drop or change its request.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments on a MEM grant while if_req=1, saturating at STARVE_MAX.
  - Clears on any IF grant, or on a MEM grant with if_req=0.
- Abandoned fetch: if if_req falls while the FSM is in GNT_IF (branch flush), the port transaction still runs to port_ack. The RESP cycle then suppresses if_valid and leaves if_rdata unchanged. The abandonment flag latches the first cycle if_req=0 and clears in IDLE.
- mem_req falling during GNT_MEM is illegal. The block still completes the transaction and pulses mem_done.
- Reset (any state, including mid-transaction): next edge gives state=IDLE, starve_cnt=0, port_req=0, port_we=0, port_addr=0, port_wdata=0, if_rdata=0, mem_rdata=0, if_valid=0, mem_done=0. An in-flight memory access is abandoned, and the memory must tolerate port_req dropping before ack.

## Timing
- Zero-wait memory (port_ack high the first cycle port_req is high):
  - cycle 0: request seen in IDLE
  - cycle 1: port_req=1, port_ack=1
  - cycle 2: RESP, valid/done=1
  - cycle 3: IDLE
  - Minimum 3 cycles per access, 1 idle decision cycle between accesses.
- Each wait state on port_ack adds one cycle. port_req stays high until the ack cycle inclusive.
- if_stall and mem_stall have zero latency from the request inputs. Each stall falls in the same cycle its completion pulse is high.
- Exactly one of GNT_IF or GNT_MEM is active at a time, and port_req is never high in IDLE or RESP.

## Test plan
- Solo fetch: if_req=1, if_addr=0x40, ack on first port_req cycle with port_rdata=0xDEADBEEF. Required response: port_req high cycle 1, if_valid cycle 2 with if_rdata=0xDEADBEEF, if_stall 1 in cycles 0–1 and 0 in cycle 2.
- Store with wait states: mem_req=1, mem_we=1, addr=0x100, wdata=0x1234, ack delayed 3 cycles. Required response: port_req/port_we/port_addr/port_wdata stable for 4 cycles, mem_done 1 cycle after ack, mem_rdata unchanged.
- Contention and starvation: both requests held continuously, STARVE_MAX=4, requesters re-raise after each pulse. Required grant order: MEM, MEM, MEM, MEM, IF, MEM…; starve_cnt reads 4 at the IF grant and 0 after it.
- Flush: fetch granted, if_req dropped in cycle 1, ack in cycle 2. Required response: no if_valid pulse and if_rdata unchanged; a pending mem_req is granted in the next IDLE.
- Reset mid-access: reset asserted in GNT_MEM before ack. Required response: next edge gives port_req=0, all outputs 0, state IDLE; mem_req still high is regranted 1 cycle after reset deasserts.
